dcache_responder: RTL
=====================

// Module: dcache_responder
// PURPOSE
//  Memory-side responder for the core's cache ports (addr/re/we/din -> dout/stall).
//  Blocking, direct-mapped, write-through, no-write-allocate cache. One request at a time.
//  Sits between one core port (icache or dcache) and the 128-bit main-memory request/response interface.
//  Instantiated once per port.
// PARAMETERS
//  IDX_BITS   6    index width; LINES = 2**IDX_BITS, 16-byte lines, one 128-bit memory beat per line
// PORTS
//  clk                 in   1    clock
//  reset               in   1    synchronous, active-high reset
//  cpu_addr            in   32   byte address: [3:2] word, [4+IDX_BITS-1:4] index, [31:4+IDX_BITS] tag
//  cpu_re              in   1    read request
//  cpu_we              in   4    byte write enables; nonzero = write request
//  cpu_din             in   32   write data, byte lanes aligned to cpu_we
//  cpu_dout            out  32   read data (registered)
//  stall               out  1    core must hold pipeline; request is already latched here
//  mem_req_valid       out  1    memory command valid
//  mem_req_ready       in   1    memory command accepted
//  mem_req_rw          out  1    1 = write, 0 = read
//  mem_req_addr        out  28   line address = addr[31:4]
//  mem_req_data_valid  out  1    write data valid
//  mem_req_data_ready  in   1    write data accepted
//  mem_req_data_bits   out  128  write data: cpu_din replicated to all four word slots
//  mem_req_data_mask   out  16   byte mask = cpu_we << (4*addr[3:2])
//  mem_resp_valid      in   1    read response beat valid
//  mem_resp_data       in   128  read response line
// BEHAVIOUR
//  Reset: all valid bits cleared; state IDLE. stall=0, cpu_dout=0, mem_req_valid=0, mem_req_data_valid=0.
//  Request acceptance: sampled at a rising edge in IDLE when (cpu_re | |cpu_we). If both are set, the write wins and cpu_re is ignored.
//  Address, we, and din are latched at acceptance. The core may change its inputs while stall=1.
//  Read hit (valid & tag match): cpu_dout = line word at edge T+1. stall stays 0. Back-to-back hits run one per cycle.
//  Read miss: go to RD_REQ; stall=1 from T+1.
//  RD_REQ: mem_req_valid=1, rw=0, addr held until mem_req_ready. Then go to RD_WAIT.
//  RD_WAIT: on mem_resp_valid, write the line, set valid, set tag, and load cpu_dout with the selected word.
//    Then go to IDLE; stall drops the same cycle the data appears.
//  Write (hit or miss): in a hit, the masked bytes of the cached line are updated at acceptance. A miss does not allocate.
//    Go to WR_REQ; stall=1.
//  WR_REQ: mem_req_valid and mem_req_data_valid both asserted, rw=1. Each valid drops independently after its own handshake.
//    Both handshakes may occur in the same cycle. Go to IDLE once both are done.
//  stall = (state != IDLE). cpu_dout holds its last loaded value through writes and stalls.
//  mem_resp_valid outside RD_WAIT is ignored. mem outputs are stable until their handshake completes.
//  Reset mid-operation (any state): abort, invalidate all lines, drop stall next cycle, and drop mem valids immediately.
//    Any response still in flight is ignored.
//  Index aliasing: a refill overwrites the old line unconditionally. Write-through means there is no dirty data to lose.
// TESTING
//  Cold read 0x0000_1004 -> stall=1, one mem read of addr 0x0000100.
//    Response 0x..._DDDD_CCCC_BBBB_AAAA (words 3..0) -> cpu_dout=0xBBBBBBBB, stall=0.
//  Repeat read 0x0000_1004, then 0x0000_100C -> no mem traffic; cpu_dout=0xBBBBBBBB, then 0xDDDDDDDD on consecutive cycles.
//  Write we=4'b0011, din=0x1234_5678 to 0x0000_1008 -> mem write with mask 0x0300, addr 0x0000100.
//    A later read of 0x0000_1008 returns 0xCCCC5678 with no refill.
//  Write miss to 0x0004_0000 -> one mem write only. A later read of 0x0004_0000 misses and refills.
//  mem_req_ready held low for 5 cycles in RD_REQ -> addr/valid stay stable and stall=1 throughout. Completes normally afterwards.
//  Assert reset during RD_WAIT, then send mem_resp_valid -> response ignored, stall=0, and a re-read of 0x0000_1004 misses.

Source files
------------

// File: rtl/dcache_responder.sv
// Blocking, direct-mapped, write-through, no-write-allocate cache between one core
// port and the 128-bit main-memory request/response interface. One request at a time.
module dcache_responder #(
  parameter int IDX_BITS = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  cpu_addr,
  input  logic         cpu_re,
  input  logic [3:0]   cpu_we,
  input  logic [31:0]  cpu_din,
  output logic [31:0]  cpu_dout,
  output logic         stall,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_rw,
  output logic [27:0]  mem_req_addr,
  output logic         mem_req_data_valid,
  input  logic         mem_req_data_ready,
  output logic [127:0] mem_req_data_bits,
  output logic [15:0]  mem_req_data_mask,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_data
);
  localparam int LINES    = 1 << IDX_BITS;
  localparam int TAG_BITS = 28 - IDX_BITS;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  state_t              state_reg;
  logic [LINES-1:0]    valid_reg;
  logic [31:2]         addr_reg;
  logic [3:0]          we_reg;
  logic [31:0]         din_reg;
  logic                rw_reg;
  logic [31:0]         dout_reg;
  logic                req_valid_reg;
  logic                data_valid_reg;

  logic [127:0]        line_mem [LINES];
  logic [TAG_BITS-1:0] tag_mem  [LINES];

  logic [IDX_BITS-1:0] in_idx;
  logic [TAG_BITS-1:0] in_tag;
  logic [1:0]          in_word;
  logic [IDX_BITS-1:0] lat_idx;
  logic [TAG_BITS-1:0] lat_tag;
  logic [1:0]          lat_word;
  logic [127:0]        in_line;
  logic [127:0]        merged_line;
  logic [15:0]         in_mask;
  logic                in_hit;
  logic                accept_wr;
  logic                accept_rd;
  logic                fill;
  logic                req_done;
  logic                data_done;
  logic                unused_addr_bits;

  assign in_idx   = cpu_addr[4 +: IDX_BITS];
  assign in_tag   = cpu_addr[31 -: TAG_BITS];
  assign in_word  = cpu_addr[3:2];
  assign lat_idx  = addr_reg[4 +: IDX_BITS];
  assign lat_tag  = addr_reg[31 -: TAG_BITS];
  assign lat_word = addr_reg[3:2];
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Lookup uses the live core address so a hit returns data at the acceptance edge.
  assign in_line   = line_mem[in_idx];
  assign in_hit    = valid_reg[in_idx] && (tag_mem[in_idx] == in_tag);
  assign in_mask   = 16'(cpu_we) << {in_word, 2'b00};
  assign accept_wr = (state_reg == IDLE) && (cpu_we != 4'b0000);
  assign accept_rd = (state_reg == IDLE) && cpu_re && (cpu_we == 4'b0000);
  assign fill      = (state_reg == RD_WAIT) && mem_resp_valid;
  assign req_done  = !req_valid_reg || mem_req_ready;
  assign data_done = !data_valid_reg || mem_req_data_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_merge
      assign merged_line[8*gi +: 8] = in_mask[gi] ? cpu_din[8*(gi%4) +: 8] : in_line[8*gi +: 8];
    end
  endgenerate

  // Line/tag storage needs no reset: the valid vector alone decides hits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill) begin
        line_mem[lat_idx] <= mem_resp_data;
        tag_mem[lat_idx]  <= lat_tag;
      end else if (accept_wr && in_hit) begin
        line_mem[in_idx] <= merged_line;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      valid_reg      <= '0;
      addr_reg       <= '0;
      we_reg         <= '0;
      din_reg        <= '0;
      rw_reg         <= 1'b0;
      dout_reg       <= '0;
      req_valid_reg  <= 1'b0;
      data_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept_wr) begin
            addr_reg       <= cpu_addr[31:2];
            we_reg         <= cpu_we;
            din_reg        <= cpu_din;
            rw_reg         <= 1'b1;
            req_valid_reg  <= 1'b1;
            data_valid_reg <= 1'b1;
            state_reg      <= WR_REQ;
          end else if (accept_rd) begin
            addr_reg <= cpu_addr[31:2];
            if (in_hit) begin
              dout_reg <= in_line[{in_word, 5'b00000} +: 32];
            end else begin
              rw_reg        <= 1'b0;
              req_valid_reg <= 1'b1;
              state_reg     <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (mem_req_ready) begin
            req_valid_reg <= 1'b0;
            state_reg     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_resp_valid) begin
            valid_reg[lat_idx] <= 1'b1;
            dout_reg           <= mem_resp_data[{lat_word, 5'b00000} +: 32];
            state_reg          <= IDLE;
          end
        end
        WR_REQ: begin
          // Command and data channels retire independently, possibly together.
          if (mem_req_ready)      req_valid_reg  <= 1'b0;
          if (mem_req_data_ready) data_valid_reg <= 1'b0;
          if (req_done && data_done) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign stall              = (state_reg != IDLE);
  assign cpu_dout           = dout_reg;
  assign mem_req_valid      = req_valid_reg;
  assign mem_req_rw         = rw_reg;
  assign mem_req_addr       = addr_reg[31:4];
  assign mem_req_data_valid = data_valid_reg;
  assign mem_req_data_bits  = {4{din_reg}};
  assign mem_req_data_mask  = 16'(we_reg) << {addr_reg[3:2], 2'b00};
endmodule
